// File: rtl/mem_pkg.sv
// Shared memory-map package: DMA state encoding, access-width codes and
// region base addresses common to the memory controller and its initiators.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    WR_HOLD = 3'd3,
    DONE    = 3'd4
  } dma_state_t;

  localparam logic [1:0]  MEM_WIDTH_WORD = 2'd0;
  localparam logic [1:0]  MEM_WIDTH_BYTE = 2'd1;
  localparam logic [1:0]  MEM_WIDTH_HALF = 2'd2;

  localparam logic [31:0] BROM_BASE = 32'h0000_0000;
  localparam logic [31:0] IMEM_BASE = 32'h2000_0000;
  localparam logic [31:0] DMEM_BASE = 32'h4000_0000;
  localparam logic [31:0] PERI_BASE = 32'h8000_0000;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Data-port bundle between the copy DMA (master) and the arbiter/memory
// controller side (slave). Signal names are from the DMA's point of view.
interface mem_copy_dma_if;
  logic        o_req;
  logic        i_gnt;
  logic [31:0] o_data_addr;
  logic [31:0] o_data_wdata;
  logic [1:0]  o_data_width;
  logic        o_data_we;
  logic        o_data_read_en;
  logic        o_data_zeroextend;
  logic [31:0] i_data_rdata;

  modport master (
    output o_req, o_data_addr, o_data_wdata, o_data_width,
           o_data_we, o_data_read_en, o_data_zeroextend,
    input  i_gnt, i_data_rdata
  );

  modport slave (
    input  o_req, o_data_addr, o_data_wdata, o_data_width,
           o_data_we, o_data_read_en, o_data_zeroextend,
    output i_gnt, i_data_rdata
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Block-copy DMA for the memory controller data port: read a word (1-cycle
// latency), write it back at the destination, 2 cycles/word under grant.
// Optional fill mode when DMA_FILL_EN is defined (writes a constant,
// 1 cycle/word, source unused).
module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
`ifdef DMA_FILL_EN
  input  logic             i_fill,
  input  logic [31:0]      i_fill_value,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  mem_copy_dma_if.master   bus
);

  dma_state_t       r_state, w_next;
  logic [31:0]      r_src, r_dst, r_hold;
  logic [LEN_W-1:0] r_len;
  logic             r_err;

  logic             w_start_fill;  // fill requested on the start cycle
  logic             w_fill_mode;   // latched mode of the running transfer
  logic [31:0]      w_fill_val;

  logic             w_accept, w_misalign, w_adv, w_last;
  logic             w_req, w_we, w_re;
  logic [31:0]      w_addr, w_wdata;

`ifdef DMA_FILL_EN
  logic             r_fill;
  logic [31:0]      r_fill_val;
  assign w_start_fill = i_fill;
  assign w_fill_mode  = r_fill;
  assign w_fill_val   = r_fill_val;
`else
  assign w_start_fill = 1'b0;
  assign w_fill_mode  = 1'b0;
  assign w_fill_val   = 32'd0;
`endif

  assign w_last = (r_len == LEN_W'(1));

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next state and data-port drive; port stays quiet unless granted
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_misalign = 1'b0;
    w_adv      = 1'b0;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_addr     = 32'd0;
    w_wdata    = 32'd0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept   = 1'b1;
          w_misalign = (!w_start_fill && (i_src[1:0] != 2'b00)) || (i_dst[1:0] != 2'b00);
          if (w_misalign || (i_len == '0)) w_next = DONE;
          else                             w_next = w_start_fill ? WR : RD;
        end
      end
      RD: begin
        w_req = 1'b1;
        if (bus.i_gnt) begin
          w_addr = r_src;
          w_re   = 1'b1;
          w_next = WR;
        end
      end
      WR: begin
        // req held here so the arbiter can keep grant across WR->RD
        w_req = 1'b1;
        if (bus.i_gnt) begin
          w_addr  = r_dst;
          w_wdata = w_fill_mode ? w_fill_val : bus.i_data_rdata;
          w_we    = 1'b1;
          w_adv   = 1'b1;
          w_next  = w_last ? DONE : (w_fill_mode ? WR : RD);
        end else begin
          // fill data is already in a register, so no hold state needed
          w_next = w_fill_mode ? WR : WR_HOLD;
        end
      end
      WR_HOLD: begin
        w_req = 1'b1;
        if (bus.i_gnt) begin
          w_addr  = r_dst;
          w_wdata = r_hold;
          w_we    = 1'b1;
          w_adv   = 1'b1;
          w_next  = w_last ? DONE : RD;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // transfer registers: latch on start, capture read data, advance per write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src  <= 32'd0;
      r_dst  <= 32'd0;
      r_len  <= '0;
      r_hold <= 32'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= w_misalign;
        if (!w_misalign && (i_len != '0)) begin
          r_src <= i_src;
          r_dst <= i_dst;
          r_len <= i_len;
        end
      end
      // read data is only valid in WR; keep it in case grant drops
      if (r_state == WR) r_hold <= bus.i_data_rdata;
      if (w_adv) begin
        r_src <= r_src + 32'd4;
        r_dst <= r_dst + 32'd4;
        r_len <= r_len - LEN_W'(1);
      end
    end
  end

`ifdef DMA_FILL_EN
  // fill-mode configuration, latched with the rest of the transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill     <= 1'b0;
      r_fill_val <= 32'd0;
    end else if (w_accept && !w_misalign && (i_len != '0)) begin
      r_fill     <= i_fill;
      r_fill_val <= i_fill_value;
    end
  end
`endif

  assign o_busy = (r_state == RD) || (r_state == WR) || (r_state == WR_HOLD);
  assign o_done = (r_state == DONE);
  assign o_err  = r_err;

  assign bus.o_req             = w_req;
  assign bus.o_data_addr       = w_addr;
  assign bus.o_data_wdata      = w_wdata;
  assign bus.o_data_we         = w_we;
  assign bus.o_data_read_en    = w_re;
  assign bus.o_data_width      = MEM_WIDTH_WORD;
  assign bus.o_data_zeroextend = 1'b1;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behaves as the memory controller/arbiter (word
// memory, 1-cycle read latency, configurable grant) and compares the final
// memory image, latency and port usage against a sequential copy model.
module tb_mem_copy_dma;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0;
`ifdef DMA_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] fill_value = '0;
`endif
  logic        busy, done, err;

  mem_copy_dma_if bus();

  mem_copy_dma #(.LEN_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_src(src), .i_dst(dst), .i_len(len),
`ifdef DMA_FILL_EN
    .i_fill(fill), .i_fill_value(fill_value),
`endif
    .o_busy(busy), .o_done(done), .o_err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // controller-side memory and activity counters
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  logic [31:0] nxt_rdata = '0;
  int rd_cnt = 0, wr_cnt = 0, viol = 0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 32'h0;
  endfunction

  initial bus.i_gnt = 1'b0;
  initial bus.i_data_rdata = '0;

  // observe the port mid-cycle; read data appears on the following cycle
  always @(negedge clk) begin
    if (bus.o_data_read_en) begin
      rd_cnt++;
      nxt_rdata = rd_mem(bus.o_data_addr);
    end else begin
      nxt_rdata = $urandom;  // garbage unless a read was issued
    end
    if (bus.o_data_we) begin
      mem[bus.o_data_addr] = bus.o_data_wdata;
      wr_cnt++;
    end
    if (!bus.i_gnt && (bus.o_data_we || bus.o_data_read_en ||
                       bus.o_data_addr != 0 || bus.o_data_wdata != 0))
      viol++;
  end

  always @(posedge clk) bus.i_data_rdata <= nxt_rdata;

  // mode: 0 = grant always, 1 = random grant, 2 = grant dropped in word-2 WR
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int mode, input bit inj, input bit fl, input logic [31:0] fv);
    bit exp_err, got_done, busy1;
    int cyc, exp_rd, exp_wr;
    exp_err = ((s[1:0] != 0) && !fl) || (d[1:0] != 0);
    for (int i = 0; i < n; i++) mem[s + 32'(4*i)] = $urandom;
    // reference: ascending word-by-word copy on a snapshot of memory
    refm = mem;
    if (!exp_err)
      for (int i = 0; i < n; i++)
        refm[d + 32'(4*i)] = fl ? fv : rd_ref(s + 32'(4*i));
    exp_rd = (exp_err || fl) ? 0 : n;
    exp_wr = exp_err ? 0 : n;

    @(posedge clk); #1;
    rd_cnt = 0; wr_cnt = 0; viol = 0;
    start = 1'b1; src = s; dst = d; len = 16'(n);
`ifdef DMA_FILL_EN
    fill = fl; fill_value = fv;
`endif
    bus.i_gnt = (mode != 1);
    cyc = 0; got_done = 0; busy1 = 0;
    while (!got_done && cyc < 2000) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (inj && cyc == 3) begin
        start = 1'b1; src = 32'h4000_0800; dst = 32'h2000_0800; len = 16'd2;
      end
      case (mode)
        1:       bus.i_gnt = ($urandom_range(0, 3) != 0);
        2:       bus.i_gnt = !(cyc == 4 || cyc == 5);
        default: bus.i_gnt = 1'b1;
      endcase
      if (cyc == 1) busy1 = busy;
      if (done) got_done = 1;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("busy_after_start", 32'(busy1), 32'(!(exp_err || n == 0)));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err", 32'(err), 32'(exp_err));
    chk("reads", rd_cnt, exp_rd);
    chk("writes", wr_cnt, exp_wr);
    chk("port_quiet_no_gnt", viol, 0);
    if (mode == 0)
      chk("latency", cyc, (exp_err || n == 0) ? 1 : (fl ? n + 1 : 2*n + 1));
    if (mode == 2)
      chk("latency_hold", cyc, 2*n + 3);
    for (int i = 0; i < n; i++)
      chk("data", rd_mem(d + 32'(4*i)), rd_ref(d + 32'(4*i)));
    @(posedge clk); #1;
    bus.i_gnt = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_flags", {26'd0, busy, done, err, bus.o_req, bus.o_data_we, bus.o_data_read_en}, 32'd0);
    chk("rst_addr", bus.o_data_addr, 32'd0);
    chk("width_word", 32'(bus.o_data_width), 32'(MEM_WIDTH_WORD));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_copy(32'h4000_0000, 32'h2000_0010, 4, 0, 0, 0, 0);
    run_copy(32'h4000_0040, 32'h2000_0040, 0, 0, 0, 0, 0);
    run_copy(32'h4000_0002, 32'h2000_0080, 4, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", 32'(err), 32'd1);
    run_copy(32'h4000_0080, 32'h2000_0080, 2, 0, 0, 0, 0);
    run_copy(32'h4000_0000, 32'h2000_0091, 3, 0, 0, 0, 0);
    run_copy(32'h4000_0000, 32'h2000_0010, 4, 2, 0, 0, 0);
    run_copy(32'h4000_0200, 32'h2000_0200, 4, 0, 1, 0, 0);
    chk("inj_untouched", rd_mem(32'h2000_0800), 32'h0);

    // reset in the middle of an 8-word copy
    @(posedge clk); #1;
    start = 1'b1; src = 32'h4000_0300; dst = 32'h2000_0300; len = 16'd8;
    bus.i_gnt = 1'b1;
    repeat (5) begin @(posedge clk); #1; start = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {26'd0, busy, done, err, bus.o_req, bus.o_data_we, bus.o_data_read_en}, 32'd0);
    chk("midrst_addr", bus.o_data_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.i_gnt = 1'b0;
    run_copy(32'h4000_0400, 32'h2000_0400, 5, 0, 0, 0, 0);

    run_copy(32'h4000_0500, 32'h4000_0508, 6, 0, 0, 0, 0);  // overlapping, ascending
    run_copy(32'hFFFF_FFF8, 32'h2000_0600, 3, 0, 0, 0, 0);  // source wraps past 0

    for (int t = 0; t < 8; t++)
      run_copy(DMEM_BASE + {$urandom_range(0, 255), 2'b00},
               IMEM_BASE + {$urandom_range(0, 255), 2'b00},
               $urandom_range(1, 8), 1, 0, 0, 0);

`ifdef DMA_FILL_EN
    run_copy(32'h0000_0003, 32'h4000_0100, 3, 0, 0, 1, 32'hDEAD_BEEF);
    run_copy(32'h0000_0000, 32'h4000_0200, 5, 1, 0, 1, $urandom);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
